// File: rtl/stream_mux_arb_if.sv
// Bundle of the per-channel input streams and the single shared output stream
// for stream_mux_arb. The arbiter sits on the slave side of this bundle.
interface stream_mux_arb_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;

  // Producers plus the consumer, seen from outside the arbiter.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_sel, out_valid
  );

  // The arbiter itself.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_sel, out_valid
  );
endinterface

// File: rtl/stream_mux_arb.sv
// N-way packet multiplexer. A winner is picked while idle (round-robin or
// fixed priority), then held until its last beat has been accepted. Beats go
// through a single registered output stage that can stream one beat per cycle.
//
// state  | meaning
// IDLE   | no grant held; arbitrate among requesting channels
// LOCKED | grant_q owns the output until its in_last beat is accepted
module stream_mux_arb #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1,
  parameter int MODE  = 0
) (
  input  logic             clock,
  input  logic             reset,
  stream_mux_arb_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [SELW-1:0]  grant_q, grant_d;
  logic [SELW-1:0]  prev_grant_q, prev_grant_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  int               rr_start;
  logic             win_found;
  logic [SELW-1:0]  winner;

  logic [N-1:0]     g_valid_vec;
  logic [N-1:0]     g_last_vec;
  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;
  logic             space;
  logic             in_xfer;
  logic             out_xfer;
  logic [N-1:0]     in_ready_c;

  // Winner search: rotate the request vector so the search start sits at bit 0.
  // Fixed priority is simply a rotation of zero.
  always_comb begin
    rr_start  = 0;
    if (MODE == 0) rr_start = (int'(prev_grant_q) + 1) % N;
    req_dbl   = {bus.in_valid, bus.in_valid};
    req_rot   = N'(req_dbl >> rr_start);
    win_found = 1'b0;
    winner    = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        winner    = SELW'((rr_start + i) % N);
      end
    end
  end

  // Granted-channel view, output space and per-channel ready.
  always_comb begin
    g_valid_vec = bus.in_valid >> grant_q;
    g_last_vec  = bus.in_last >> grant_q;
    g_valid     = g_valid_vec[0];
    g_last      = g_last_vec[0];
    g_data      = WIDTH'(bus.in_data >> (int'(grant_q) * WIDTH));
    space       = !out_valid_q || bus.out_ready;
    in_ready_c  = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_c[i] = (state_q == LOCKED) && (grant_q == SELW'(i)) && space;
    end
    in_xfer     = (state_q == LOCKED) && g_valid && space;
    out_xfer    = out_valid_q && bus.out_ready;
  end

  // Next-state: arbitration in IDLE, beat loading and packet release in LOCKED.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    prev_grant_d = prev_grant_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;

    if (out_xfer) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (in_xfer) begin
          out_data_d  = g_data;
          out_last_d  = g_last;
          out_sel_d   = grant_q;
          out_valid_d = 1'b1;
          if (g_last) begin
            state_d      = IDLE;
            prev_grant_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset restarts arbitration from channel 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      prev_grant_q <= SELW'(N - 1);
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_sel_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      prev_grant_q <= prev_grant_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: a round-robin instance (b0/u0) and a
// fixed-priority instance (b1/u1) sharing one clock and reset.
module tb_stream_mux_arb;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stream_mux_arb_if #(.WIDTH(16), .N(4), .SELW(2)) b0 ();
  stream_mux_arb_if #(.WIDTH(16), .N(4), .SELW(2)) b1 ();

  stream_mux_arb #(.WIDTH(16), .N(4), .SELW(2), .MODE(0)) u0 (
    .clock(clock), .reset(reset), .bus(b0.slave));
  stream_mux_arb #(.WIDTH(16), .N(4), .SELW(2), .MODE(1)) u1 (
    .clock(clock), .reset(reset), .bus(b1.slave));

  int n_chk  = 0;
  int n_pass = 0;

  // Producer model for b0: channel i sends p_len[i] beats p_base[i]+idx.
  logic [15:0] p_base [4];
  int          p_len  [4];
  int          p_idx  [4];
  logic        p_act  [4];
  logic        p_rep  [4];

  logic [3:0]  acc0;
  logic        oxf0;
  logic [15:0] od0;
  logic        ol0;
  logic [1:0]  os0;
  int          in_cnt;
  int          out_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive0();
    for (int i = 0; i < 4; i++) begin
      b0.in_valid[i]          = p_act[i];
      b0.in_data[i*16 +: 16]  = p_base[i] + 16'(p_idx[i]);
      b0.in_last[i]           = (p_idx[i] == p_len[i] - 1);
    end
  endtask

  task automatic clr_prod();
    for (int i = 0; i < 4; i++) begin
      p_base[i] = '0;
      p_len[i]  = 1;
      p_idx[i]  = 0;
      p_act[i]  = 1'b0;
      p_rep[i]  = 1'b0;
    end
    drive0();
  endtask

  // Sample handshakes mid-cycle, cross the edge, then advance the producers.
  task automatic tick();
    @(negedge clock);
    acc0 = b0.in_valid & b0.in_ready;
    oxf0 = b0.out_valid & b0.out_ready;
    od0  = b0.out_data;
    ol0  = b0.out_last;
    os0  = b0.out_sel;
    in_cnt  += $countones(acc0);
    out_cnt += int'(oxf0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc0[i]) begin
        p_idx[i]++;
        if (p_idx[i] == p_len[i]) begin
          p_idx[i] = 0;
          if (!p_rep[i]) p_act[i] = 1'b0;
        end
      end
    end
    drive0();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ob;
    b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    b1.in_valid  = '0;
    b1.in_last   = '0;
    b1.in_data   = '0;
    in_cnt  = 0;
    out_cnt = 0;
    clr_prod();

    // Reset, then idle for 20 cycles.
    tick();
    tick();
    chk("rst_valid", b0.out_valid, 0);
    chk("rst_ready", b0.in_ready, 0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle_valid0", b0.out_valid, 0);
      chk("idle_ready0", b0.in_ready, 0);
      chk("idle_valid1", b1.out_valid, 0);
      chk("idle_ready1", b1.in_ready, 0);
    end
    chk("idle_data", b0.out_data, 0);
    chk("idle_sel", b0.out_sel, 0);
    chk("idle_last", b0.out_last, 0);

    // Single channel: ch2 sends A001..A003.
    p_base[2] = 16'hA001; p_len[2] = 3; p_act[2] = 1'b1;
    drive0();
    tick();
    chk("s_bubble_valid", b0.out_valid, 0);
    chk("s_ready", b0.in_ready, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s_valid", b0.out_valid, 1);
      chk("s_data", b0.out_data, 32'hA001 + k);
      chk("s_sel", b0.out_sel, 2);
      chk("s_last", b0.out_last, (k == 2) ? 1 : 0);
    end
    chk("s_idle_ready", b0.in_ready, 0);
    tick();
    chk("s_end_valid", b0.out_valid, 0);
    chk("s_end_ready", b0.in_ready, 0);

    // Round-robin fairness with 1-beat packets on all channels.
    clr_prod();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      p_base[i] = 16'(32'h100 * i); p_len[i] = 1; p_act[i] = 1'b1; p_rep[i] = 1'b1;
    end
    drive0();
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k % 2 == 0) begin
        chk("rr_valid", b0.out_valid, 1);
        chk("rr_sel", b0.out_sel, (k / 2 - 1) % 4);
        chk("rr_data", b0.out_data, 32'h100 * ((k / 2 - 1) % 4));
      end else begin
        chk("rr_bubble", b0.out_valid, 0);
      end
    end
    clr_prod();
    do_reset();

    // Fixed priority: ch1 and ch3 both request; ch1 drops after its 4th packet.
    b1.in_data  = {16'h0333, 16'h0000, 16'h0111, 16'h0000};
    b1.in_last  = 4'b1111;
    b1.in_valid = 4'b1010;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k % 2 == 0) begin
        chk("fp_valid", b1.out_valid, 1);
        chk("fp_sel", b1.out_sel, (k <= 8) ? 1 : 3);
        chk("fp_data", b1.out_data, (k <= 8) ? 32'h0111 : 32'h0333);
      end else begin
        chk("fp_bubble", b1.out_valid, 0);
      end
      if (k <= 8) chk("fp_ch3_wait", b1.in_ready[3], 0);
      if (k == 8) b1.in_valid = 4'b1000;
    end
    b1.in_valid = '0;

    // Back-pressure during a 4-beat ch0 packet.
    clr_prod();
    do_reset();
    in_cnt  = 0;
    out_cnt = 0;
    ob      = 0;
    p_base[0] = 16'hB000; p_len[0] = 4; p_act[0] = 1'b1;
    drive0();
    for (int k = 0; k < 16; k++) begin
      b0.out_ready = !(k >= 4 && k <= 8);
      #1;
      if (!b0.out_ready) begin
        chk("bp_ready", b0.in_ready, 0);
        chk("bp_valid", b0.out_valid, 1);
        chk("bp_frozen", b0.out_data, 32'hB002);
      end
      tick();
      if (oxf0) begin
        chk("bp_out_data", od0, 32'hB000 + ob);
        chk("bp_out_last", ol0, (ob == 3) ? 1 : 0);
        ob++;
      end
    end
    chk("bp_in_cnt", in_cnt, 4);
    chk("bp_out_cnt", out_cnt, 4);
    b0.out_ready = 1'b1;

    // Packet lock, then asynchronous reset in the middle of ch1's packet.
    clr_prod();
    do_reset();
    p_base[0] = 16'hC000; p_len[0] = 4; p_act[0] = 1'b1;
    p_base[1] = 16'hD000; p_len[1] = 3; p_act[1] = 1'b1;
    drive0();
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 5) chk("lk_ch1_wait", b0.in_ready[1], 0);
      if (k >= 2 && k <= 5) begin
        chk("lk_valid", b0.out_valid, 1);
        chk("lk_sel", b0.out_sel, 0);
        chk("lk_data", b0.out_data, 32'hC000 + (k - 2));
        chk("lk_last", b0.out_last, (k == 5) ? 1 : 0);
      end else if (k == 6) begin
        chk("lk_bubble", b0.out_valid, 0);
      end else if (k == 7) begin
        chk("lk_ch1_sel", b0.out_sel, 1);
        chk("lk_ch1_data", b0.out_data, 32'hD000);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", b0.out_valid, 0);
    chk("ar_data", b0.out_data, 0);
    chk("ar_sel", b0.out_sel, 0);
    chk("ar_ready", b0.in_ready, 0);
    tick();
    tick();
    reset = 1'b0;
    p_idx[1] = 0;
    p_base[0] = 16'hE000; p_len[0] = 1; p_idx[0] = 0; p_act[0] = 1'b1;
    drive0();
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) begin
        chk("pr_valid", b0.out_valid, 1);
        chk("pr_sel", b0.out_sel, 0);
        chk("pr_data", b0.out_data, 32'hE000);
        chk("pr_last", b0.out_last, 1);
      end else if (k == 4) begin
        chk("pr_ch1_sel", b0.out_sel, 1);
        chk("pr_ch1_data", b0.out_data, 32'hD000);
      end else begin
        chk("pr_bubble", b0.out_valid, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
